// File: rtl/rr_mux_pkg.sv
// Shared types and constants for the 4-channel round-robin multiplexer.
package rr_mux_pkg;

    localparam int unsigned N_CHAN = 4;

    typedef logic [1:0] chan_idx_t;

endpackage

// File: rtl/rr_arbiter_4.sv
// Round-robin arbiter over four requesters; owns the rotating priority pointer.
module rr_arbiter_4
    import rr_mux_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CHAN-1:0] req,
    input  logic              advance,
    output chan_idx_t         grant_idx,
    output logic              any_req
);

    chan_idx_t ptr;

    // Scan from the farthest offset down so the nearest requester at or after ptr wins.
    always_comb begin
        grant_idx = ptr;
        for (int k = N_CHAN - 1; k >= 0; k--) begin
            if (req[ptr + 2'(k)]) begin
                grant_idx = ptr + 2'(k);
            end
        end
        any_req = |req;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= grant_idx + 2'd1;
        end
    end

endmodule

// File: rtl/rr_mux_4_1.sv
// Round-robin arbitrating 4:1 multiplexer with a one-entry registered output stage.
module rr_mux_4_1
    import rr_mux_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CHAN-1:0] in_valid,
    input  logic [WIDTH-1:0]  in_data0,
    input  logic [WIDTH-1:0]  in_data1,
    input  logic [WIDTH-1:0]  in_data2,
    input  logic [WIDTH-1:0]  in_data3,
    output logic [N_CHAN-1:0] in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output chan_idx_t         out_sel
);

    logic [WIDTH-1:0] data_arr [N_CHAN];
    chan_idx_t        grant_idx;
    logic             any_req;
    logic             load;
    logic             advance;

    always_comb begin
        data_arr[0] = in_data0;
        data_arr[1] = in_data1;
        data_arr[2] = in_data2;
        data_arr[3] = in_data3;
    end

    assign load    = !out_valid || out_ready;
    assign advance = load && any_req;

    rr_arbiter_4 u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (in_valid),
        .advance   (advance),
        .grant_idx (grant_idx),
        .any_req   (any_req)
    );

    // Accept is a pure function of valid/ready state; data never feeds back into it.
    assign in_ready = (advance && !rst) ? (N_CHAN'(1) << grant_idx) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (load) begin
            out_valid <= any_req;
            if (any_req) begin
                out_data <= data_arr[grant_idx];
                out_sel  <= grant_idx;
            end
        end
    end

endmodule

// File: tb/tb_rr_mux_4_1.sv
// Self-checking bench for rr_mux_4_1: behavioural model plus directed literal checks.
module tb_rr_mux_4_1;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] in_valid;
    logic [3:0] din [4];
    logic [3:0] in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic [1:0] out_sel;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Model state: what the output stage and priority pointer must hold.
    bit       m_valid = 1'b0;
    bit [3:0] m_data  = 4'd0;
    int       m_sel   = 0;
    int       m_ptr   = 0;

    always #5 clk = ~clk;

    rr_mux_4_1 #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data0  (din[0]),
        .in_data1  (din[1]),
        .in_data2  (din[2]),
        .in_data3  (din[3]),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic int m_grant(input logic [3:0] v);
        for (int k = 0; k < 4; k++) begin
            if (v[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
        end
        return 0;
    endfunction

    function automatic logic [3:0] m_ready();
        if (rst || (m_valid && !out_ready) || in_valid == 4'b0) return 4'b0;
        return 4'(1 << m_grant(in_valid));
    endfunction

    // Model update at each rising edge from the inputs held across it.
    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1'b0;
            m_data  = 4'd0;
            m_sel   = 0;
            m_ptr   = 0;
        end else if (!m_valid || out_ready) begin
            m_valid = (in_valid != 4'b0);
            if (in_valid != 4'b0) begin
                m_sel   = m_grant(in_valid);
                m_data  = din[m_sel];
                m_ptr   = (m_sel + 1) % 4;
            end
        end
    end

    // Per-cycle comparison against the model, after inputs have settled.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            chk("model_in_ready", 32'(in_ready), 32'(m_ready()));
            chk("model_out_valid", 32'(out_valid), 32'(m_valid));
            chk("model_out_data", 32'(out_data), 32'(m_data));
            chk("model_out_sel", 32'(out_sel), 32'(m_sel));
        end
    end

    task automatic cyc(input logic r, input logic [3:0] v, input logic [3:0] d0,
                       input logic [3:0] d1, input logic [3:0] d2, input logic [3:0] d3,
                       input logic ordy);
        @(negedge clk);
        #1;
        rst = r; in_valid = v; out_ready = ordy;
        din[0] = d0; din[1] = d1; din[2] = d2; din[3] = d3;
        #1;
    endtask

    logic [3:0] rr_rdy [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    logic [1:0] rr_sel [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [3:0] rr_dat [6] = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hA, 4'hB};
    logic [3:0] sk_rdy [4] = '{4'b1000, 4'b0010, 4'b1000, 4'b0010};
    logic [3:0] sk_dat [4] = '{4'd3, 4'd7, 4'd3, 4'd7};

    initial begin
        rst = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        din[0] = 4'h1; din[1] = 4'h2; din[2] = 4'h3; din[3] = 4'h4;

        // Reset held with all channels requesting.
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, 4'b1111, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1);
            chk("reset_in_ready", 32'(in_ready), 32'h0);
            chk("reset_out_valid", 32'(out_valid), 32'h0);
            chk("reset_out_data", 32'(out_data), 32'h0);
            chk("reset_out_sel", 32'(out_sel), 32'h0);
        end

        // Full round robin at full rate.
        for (int i = 0; i < 7; i++) begin
            cyc(1'b0, (i < 6) ? 4'b1111 : 4'b0000, 4'hA, 4'hB, 4'hC, 4'hD, 1'b1);
            if (i < 6) chk("rr_in_ready", 32'(in_ready), 32'(rr_rdy[i]));
            if (i > 0) begin
                chk("rr_out_sel", 32'(out_sel), 32'(rr_sel[i-1]));
                chk("rr_out_data", 32'(out_data), 32'(rr_dat[i-1]));
            end
        end

        // Idle channels skipped; channel 2 carries X and never requests.
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, (i < 4) ? 4'b1010 : 4'b0000, 4'h0, 4'd7, 4'bxxxx, 4'd3, 1'b1);
            if (i < 4) chk("skip_in_ready", 32'(in_ready), 32'(sk_rdy[i]));
            if (i > 0) chk("skip_out_data", 32'(out_data), 32'(sk_dat[i-1]));
        end

        // Backpressure holds the word and blocks all accepts.
        cyc(1'b0, 4'b0001, 4'd5, 4'd6, 4'd8, 4'd0, 1'b1);
        chk("bp_load_ready", 32'(in_ready), 32'b0001);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 4'b0110, 4'd5, 4'd6, 4'd8, 4'd0, 1'b0);
            chk("bp_in_ready", 32'(in_ready), 32'h0);
            chk("bp_out_data", 32'(out_data), 32'd5);
            chk("bp_out_sel", 32'(out_sel), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
        end
        cyc(1'b0, 4'b0110, 4'd5, 4'd6, 4'd8, 4'd0, 1'b1);
        chk("bp_release_ready", 32'(in_ready), 32'b0010);
        cyc(1'b0, 4'b0000, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
        chk("bp_release_sel", 32'(out_sel), 32'd1);
        chk("bp_release_data", 32'(out_data), 32'd6);

        // Pointer wrap after channel 3, then a lone requester at full rate.
        cyc(1'b0, 4'b1000, 4'd1, 4'd0, 4'd0, 4'd4, 1'b1);
        chk("wrap_g3_ready", 32'(in_ready), 32'b1000);
        cyc(1'b0, 4'b0001, 4'd1, 4'd0, 4'd0, 4'd4, 1'b1);
        chk("wrap_g0_ready", 32'(in_ready), 32'b0001);
        chk("wrap_g3_sel", 32'(out_sel), 32'd3);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, (i < 3) ? 4'b0100 : 4'b0000, 4'd1, 4'd0, 4'd2, 4'd4, 1'b1);
            if (i < 3) chk("single_ready", 32'(in_ready), 32'b0100);
            if (i == 0) chk("wrap_g0_sel", 32'(out_sel), 32'd0);
            else begin
                chk("single_sel", 32'(out_sel), 32'd2);
                chk("single_valid", 32'(out_valid), 32'd1);
            end
        end

        // Reset discards a held word and restores channel 0 priority.
        cyc(1'b0, 4'b0001, 4'd9, 4'd0, 4'd0, 4'd0, 1'b1);
        cyc(1'b0, 4'b0000, 4'd9, 4'd0, 4'd0, 4'd0, 1'b0);
        chk("hold9_valid", 32'(out_valid), 32'd1);
        chk("hold9_data", 32'(out_data), 32'd9);
        cyc(1'b1, 4'b1111, 4'd1, 4'd2, 4'd3, 4'd4, 1'b0);
        chk("mid_rst_ready", 32'(in_ready), 32'h0);
        cyc(1'b0, 4'b1111, 4'd1, 4'd2, 4'd3, 4'd4, 1'b1);
        chk("post_rst_valid", 32'(out_valid), 32'd0);
        chk("post_rst_ready", 32'(in_ready), 32'b0001);
        cyc(1'b0, 4'b0000, 4'd1, 4'd2, 4'd3, 4'd4, 1'b1);
        chk("post_rst_sel", 32'(out_sel), 32'd0);
        chk("post_rst_data", 32'(out_data), 32'd1);

        @(negedge clk);
        #5;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
